int_ctrl_n: RTL and testbench



---
 rtl/int_ctrl_n.sv | 112 +++++++++++
 tb/tb_int_ctrl_n.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/int_ctrl_n.sv
// N-channel interrupt controller: rising-edge capture into pending flags, enable/select
// eligibility, lowest-index-wins grant held until CPU ack, then one idle gap cycle.
module int_ctrl_n #(
  parameter int N    = 4,
  parameter int ID_W = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            m,
  input  logic [N-1:0]    irq,
  input  logic [N-1:0]    sel,
  input  logic [N-1:0]    en,
  input  logic            ack,
  output logic            y,
  output logic [ID_W-1:0] id,
  output logic [N-1:0]    ovf,
  output logic [1:0]      dbg_state,
  output logic [N-1:0]    dbg_pending
);

  if ((2 ** ID_W) < N) begin : g_bad_id_w
    $error("ID_W too narrow for N channels");
  end

  // Handshake: y=1 means request outstanding; it is consumed at the first rising
  // clk edge where ack=1 while y=1. ack at any other time has no effect.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    irq_q;
  logic [N-1:0]    pending_q, pending_d;
  logic [N-1:0]    ovf_q, ovf_d;
  logic [ID_W-1:0] id_q, id_d;

  logic [N-1:0]    edge_det;
  logic [N-1:0]    cand;
  logic [N-1:0]    clr_mask;
  logic [ID_W-1:0] win_id;
  logic            win_found;
  logic            take_ack;

  // Datapath: edge detect, eligibility and fixed-priority pick
  always_comb begin
    edge_det  = irq & ~irq_q;
    cand      = m ? (pending_q & en & sel) : (pending_q & en);
    win_id    = '0;
    win_found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (cand[i] && !win_found) begin
        win_id    = ID_W'(i);
        win_found = 1'b1;
      end
    end
    take_ack = (state_q == S_REQ) && ack;
    clr_mask = '0;
    for (int i = 0; i < N; i++) begin
      clr_mask[i] = take_ack && (id_q == ID_W'(i));
    end
    // A fresh edge on the acked channel re-pends it but is not an overflow.
    pending_d = (pending_q & ~clr_mask) | edge_det;
    ovf_d     = (ovf_q | (edge_det & pending_q)) & ~clr_mask;
    id_d      = id_q;
    if ((state_q == S_IDLE) && win_found) begin
      id_d = win_id;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_q     <= '0;
      pending_q <= '0;
      ovf_q     <= '0;
      id_q      <= '0;
    end else begin
      irq_q     <= irq;
      pending_q <= pending_d;
      ovf_q     <= ovf_d;
      id_q      <= id_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (win_found) state_d = S_REQ;
      S_REQ:   if (ack) state_d = S_GAP;
      S_GAP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    y           = (state_q == S_REQ);
    id          = id_q;
    ovf         = ovf_q;
    dbg_state   = state_q;
    dbg_pending = pending_q;
  end

endmodule

// File: tb/tb_int_ctrl_n.sv
// Directed bench for int_ctrl_n (N=4): hand-computed expectations after each clock edge.
module tb_int_ctrl_n;

  localparam int N    = 4;
  localparam int ID_W = 2;

  logic            clk;
  logic            rst_n;
  logic            m;
  logic [N-1:0]    irq;
  logic [N-1:0]    sel;
  logic [N-1:0]    en;
  logic            ack;
  logic            y;
  logic [ID_W-1:0] id;
  logic [N-1:0]    ovf;
  logic [1:0]      dbg_state;
  logic [N-1:0]    dbg_pending;

  int checks = 0;
  int errors = 0;
  int grants = 0;
  logic prev_y = 1'b0;

  int_ctrl_n #(.N(N), .ID_W(ID_W)) dut (
    .clk(clk), .rst_n(rst_n), .m(m), .irq(irq), .sel(sel), .en(en), .ack(ack),
    .y(y), .id(id), .ovf(ovf), .dbg_state(dbg_state), .dbg_pending(dbg_pending)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle; inputs change and outputs are sampled here.
  task automatic step();
    @(posedge clk);
    #1;
    if (y && !prev_y) grants++;
    prev_y = y;
  endtask

  initial begin
    int g0;
    rst_n = 1'b0; m = 1'b0; irq = '0; sel = '0; en = 4'b1111; ack = 1'b0;
    step();
    chk("rst_y", y, 0);
    chk("rst_id", id, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_pend", dbg_pending, 0);
    chk("rst_state", dbg_state, 0);
    rst_n = 1'b1;
    step();

    // single edge on channel 2
    irq = 4'b0100; step();
    chk("t1_pend", dbg_pending, 4'b0100);
    chk("t1_y_early", y, 0);
    irq = 4'b0000; step();
    chk("t1_y", y, 1);
    chk("t1_id", id, 2);
    chk("t1_state_req", dbg_state, 1);
    step();
    chk("t1_y_hold", y, 1);
    ack = 1'b1; step();
    chk("t1_y_ack", y, 0);
    chk("t1_pend_clr", dbg_pending, 0);
    chk("t1_state_gap", dbg_state, 2);
    ack = 1'b0; step();
    chk("t1_state_idle", dbg_state, 0);
    chk("t1_id_held", id, 2);

    // priority: channels 1 and 3 together
    g0 = grants;
    irq = 4'b1010; step();
    chk("t2_pend", dbg_pending, 4'b1010);
    irq = 4'b0000; step();
    chk("t2_id1", id, 1);
    chk("t2_y1", y, 1);
    ack = 1'b1; step();
    chk("t2_pend_after", dbg_pending, 4'b1000);
    ack = 1'b0; step();
    chk("t2_gap_y", y, 0);
    step();
    chk("t2_id3", id, 3);
    chk("t2_y3", y, 1);
    ack = 1'b1; step();
    ack = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("t2_grants", grants - g0, 2);
    chk("t2_idle_y", y, 0);

    // polled mode
    m = 1'b1; sel = 4'b0100;
    irq = 4'b0101; step();
    chk("t3_pend", dbg_pending, 4'b0101);
    irq = 4'b0000; step();
    chk("t3_id", id, 2);
    chk("t3_y", y, 1);
    sel = 4'b0000; ack = 1'b1; step();
    chk("t3_pend_left", dbg_pending, 4'b0001);
    ack = 1'b0; step(); step(); step();
    chk("t3_y_sel0", y, 0);
    chk("t3_pend_kept", dbg_pending, 4'b0001);
    m = 1'b0; step();
    chk("t3_pri_id0", id, 0);
    chk("t3_pri_y", y, 1);
    ack = 1'b1; step();
    ack = 1'b0; step(); step();
    chk("t3_pend_empty", dbg_pending, 0);

    // overflow, then edge in the ack cycle
    irq = 4'b0010; step();
    irq = 4'b0000; step();
    chk("t4_id", id, 1);
    chk("t4_ovf0", ovf, 0);
    irq = 4'b0010; step();
    chk("t4_ovf_set", ovf, 4'b0010);
    irq = 4'b0000; step();
    ack = 1'b1; irq = 4'b0010; step();
    chk("t4_ovf_clr", ovf, 0);
    chk("t4_pend_set", dbg_pending, 4'b0010);
    chk("t4_y_gap", y, 0);
    ack = 1'b0; step();
    chk("t4_y_idle", y, 0);
    step();
    chk("t4_y_again", y, 1);
    chk("t4_id_again", id, 1);
    irq = 4'b0000; ack = 1'b1; step();
    ack = 1'b0; step(); step();

    // enable masking
    en = 4'b1110;
    irq = 4'b0001; step();
    chk("t5_pend", dbg_pending, 4'b0001);
    irq = 4'b0000; step(); step();
    chk("t5_masked_y", y, 0);
    en = 4'b1111; step();
    chk("t5_y", y, 1);
    chk("t5_id", id, 0);
    en = 4'b1110; step();
    chk("t5_y_kept", y, 1);
    ack = 1'b1; step();
    chk("t5_pend_clr", dbg_pending, 0);
    ack = 1'b0; en = 4'b1111; step(); step();

    // async reset mid-request
    irq = 4'b0100; step();
    irq = 4'b0000; step();
    irq = 4'b0100; step();
    chk("t6_y_pre", y, 1);
    chk("t6_ovf_pre", ovf, 4'b0100);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_y", y, 0);
    chk("t6_rst_ovf", ovf, 0);
    chk("t6_rst_pend", dbg_pending, 0);
    chk("t6_rst_state", dbg_state, 0);
    irq = 4'b1000;
    #1 rst_n = 1'b1;
    prev_y = 1'b0;
    step();
    chk("t6_pend_rel", dbg_pending, 4'b1000);
    chk("t6_y_rel", y, 0);
    step();
    chk("t6_y_grant", y, 1);
    chk("t6_id_grant", id, 3);
    ack = 1'b1; step();
    ack = 1'b0; irq = '0; step();
    chk("t6_end_y", y, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
